// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state, command and register-map definitions for the APB master
package apb_pkg;

    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Command word at the default bus geometry; the top builds the same
    // layout at its own parameterised widths.
    typedef struct packed {
        logic                          write;
        logic [DEF_ADDR_WIDTH-1:0]     addr;
        logic [DEF_DATA_WIDTH*8-1:0]   wdata;
    } apb_cmd_t;

    // Register map of the paired responder
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_DATA_STATUS   = 3'd0;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_ERR_STATUS    = 3'd1;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_BIT_PERIOD_LO = 3'd2;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_BIT_PERIOD_HI = 3'd3;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_DATA_SIZE     = 3'd4;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_RX_DATA       = 3'd6;

    // Width of a packed {write, addr, wdata} command word
    function automatic int cmd_width(input int addr_width, input int data_width);
        return 1 + addr_width + data_width * 8;
    endfunction

endpackage

// File: rtl/apb_master_cmd_fifo.sv
// rtl/apb_master_cmd_fifo.sv - two-entry command buffer feeding the APB master
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int WIDTH = cmd_width(DEF_ADDR_WIDTH, DEF_DATA_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push_fire;
    logic             pop_fire;

    // Not ready while held in reset so nothing slips in before the buffer is cleared
    assign push_ready = !rst && (count != 2'd2);
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop && (count != 2'd0);
    assign pop_data   = mem[rd_ptr];
    assign empty      = (count == 2'd0);

    // Pointer and occupancy tracking; push+pop together leaves the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_fire) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_fire) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - queued command to APB SETUP/ACCESS sequencer with one-cycle completion pulse
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH*8-1:0] cmd_wdata,
    output logic                    rsp_valid,
    output logic                    rsp_write,
    output logic [DATA_WIDTH*8-1:0] rsp_rdata,
    output logic                    rsp_error,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH*8-1:0] pwdata,
    input  logic [DATA_WIDTH*8-1:0] prdata,
    input  logic                    pslverr
);

    localparam int DW = DATA_WIDTH * 8;
    localparam int CW = cmd_width(ADDR_WIDTH, DATA_WIDTH);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DW-1:0]         wdata;
    } cmd_t;

    cmd_t       push_cmd;
    cmd_t       head_cmd;
    logic       fifo_empty;
    logic       pop;
    logic       load_head;
    logic       psel_next;
    logic       penable_next;
    apb_state_t state;
    apb_state_t state_next;

    assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    apb_cmd_fifo #(
        .WIDTH (CW)
    ) u_cmd_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (cmd_valid),
        .push_ready (cmd_ready),
        .push_data  (push_cmd),
        .pop        (pop),
        .pop_data   (head_cmd),
        .empty      (fifo_empty)
    );

    // Next state, head pop and head load; fifo_empty in ACCESS already reflects the SETUP pop
    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        load_head    = 1'b0;
        psel_next    = 1'b0;
        penable_next = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = SETUP;
                    load_head  = 1'b1;
                end
            end
            SETUP: begin
                state_next = ACCESS;
                pop        = 1'b1;
            end
            ACCESS: begin
                if (!fifo_empty) begin
                    state_next = SETUP;
                    load_head  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        psel_next    = (state_next != IDLE);
        penable_next = (state_next == ACCESS);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered bus outputs; address/data/direction only change on entry to SETUP
    always_ff @(posedge clk) begin
        if (rst) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else begin
            psel    <= psel_next;
            penable <= penable_next;
            if (load_head) begin
                pwrite <= head_cmd.write;
                paddr  <= head_cmd.addr;
                pwdata <= head_cmd.wdata;
            end
        end
    end

    // Completion pulse: responder return is captured on the edge leaving ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else if (state == ACCESS) begin
            rsp_valid <= 1'b1;
            rsp_write <= pwrite;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_error <= pslverr;
        end else begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master with a behavioural APB responder
module tb_apb_master;
    import apb_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [2:0] cmd_addr = 3'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       cmd_ready, rsp_valid, rsp_write, rsp_error;
    logic [7:0] rsp_rdata, pwdata, prdata;
    logic       psel, penable, pwrite, pslverr;
    logic [2:0] paddr;

    int total = 0;
    int bad = 0;

    apb_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pslverr(pslverr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder register file
    logic [15:0] bit_period = 16'd0;
    logic [7:0]  data_size  = 8'd0;
    logic [7:0]  rx_data    = 8'd0;
    logic [7:0]  err_status = 8'd0;
    logic        data_ready = 1'b0;

    function automatic logic [7:0] slave_read(input logic [2:0] a);
        case (a)
            REG_DATA_STATUS:   return {7'd0, data_ready};
            REG_ERR_STATUS:    return err_status;
            REG_BIT_PERIOD_LO: return bit_period[7:0];
            REG_BIT_PERIOD_HI: return bit_period[15:8];
            REG_DATA_SIZE:     return data_size;
            REG_RX_DATA:       return rx_data;
            default:           return 8'd0;
        endcase
    endfunction

    function automatic logic slave_err(input logic w, input logic [2:0] a);
        if (a == 3'd5 || a == 3'd7) return 1'b1;
        if (w && (a == REG_DATA_STATUS || a == REG_ERR_STATUS || a == REG_RX_DATA)) return 1'b1;
        return 1'b0;
    endfunction

    always_comb begin
        case (paddr)
            REG_DATA_STATUS:   prdata = {7'd0, data_ready};
            REG_ERR_STATUS:    prdata = err_status;
            REG_BIT_PERIOD_LO: prdata = bit_period[7:0];
            REG_BIT_PERIOD_HI: prdata = bit_period[15:8];
            REG_DATA_SIZE:     prdata = data_size;
            REG_RX_DATA:       prdata = rx_data;
            default:           prdata = 8'd0;
        endcase
    end

    always_comb begin
        pslverr = 1'b0;
        if (psel && penable) begin
            if (paddr == 3'd5 || paddr == 3'd7) pslverr = 1'b1;
            else if (pwrite && (paddr == REG_DATA_STATUS || paddr == REG_ERR_STATUS || paddr == REG_RX_DATA)) pslverr = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (psel && penable && pwrite && !pslverr) begin
            case (paddr)
                REG_BIT_PERIOD_LO: bit_period[7:0]  <= pwdata;
                REG_BIT_PERIOD_HI: bit_period[15:8] <= pwdata;
                REG_DATA_SIZE:     data_size        <= pwdata;
                default: ;
            endcase
        end
    end

    // Transaction-level model: queue of pending commands, current transfer and its phase
    apb_cmd_t   mq[$];
    apb_cmd_t   cur = '0;
    int         phase = 0;
    logic       m_rsp_valid = 1'b0;
    logic       m_rsp_write = 1'b0;
    logic [7:0] m_rsp_rdata = 8'd0;
    logic       m_rsp_error = 1'b0;
    logic       model_live = 1'b0;

    always @(posedge clk) begin
        int   pre;
        logic acc;
        model_live = 1'b1;
        if (rst) begin
            mq.delete();
            phase = 0;
            cur = '0;
            m_rsp_valid = 1'b0;
        end else begin
            pre = mq.size();
            acc = cmd_valid && (pre < 2);
            m_rsp_valid = (phase == 2);
            if (phase == 2) begin
                m_rsp_write = cur.write;
                m_rsp_rdata = cur.write ? 8'h00 : slave_read(cur.addr);
                m_rsp_error = slave_err(cur.write, cur.addr);
            end
            if (phase == 0) begin
                if (pre > 0) begin cur = mq[0]; phase = 1; end
            end else if (phase == 1) begin
                void'(mq.pop_front());
                phase = 2;
            end else begin
                if (mq.size() > 0) begin cur = mq[0]; phase = 1; end
                else phase = 0;
            end
            if (acc) mq.push_back('{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata});
        end
    end

    typedef struct { logic w; logic [7:0] d; logic e; } rsp_t;
    rsp_t       rlog[$];
    logic [1:0] trace[$];

    // Per-cycle compare against the model, plus logs for the directed checks
    always @(negedge clk) begin
        if (model_live) begin
            chk("psel", psel, phase != 0);
            chk("penable", penable, phase == 2);
            chk("paddr", paddr, cur.addr);
            chk("pwrite", pwrite, cur.write);
            chk("pwdata", pwdata, cur.wdata);
            chk("cmd_ready", cmd_ready, !rst && (mq.size() < 2));
            chk("rsp_valid", rsp_valid, m_rsp_valid);
            if (m_rsp_valid) begin
                chk("rsp_write", rsp_write, m_rsp_write);
                chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
                chk("rsp_error", rsp_error, m_rsp_error);
            end
            trace.push_back({psel, penable});
            if (rsp_valid) rlog.push_back('{w: rsp_write, d: rsp_rdata, e: rsp_error});
        end
    end

    int acc_cnt = 0;
    int first_stall = -1;

    task automatic send(input logic w, input logic [2:0] a, input logic [7:0] d);
        logic ok;
        int   n;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            @(negedge clk);
            ok = cmd_ready;
            if (!ok && first_stall < 0) first_stall = acc_cnt;
            @(posedge clk); #1;
            n++;
        end
        chk("send_accept", ok, 1);
        if (ok) acc_cnt++;
    endtask

    task automatic wait_rsp(input int n);
        int k;
        k = 0;
        while (rlog.size() < n && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rsp_count", rlog.size(), n);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic found;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_reset", cmd_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_release", cmd_ready, 1);
        chk("reset_out_bus", {psel, penable, pwrite, paddr, pwdata}, 0);
        chk("reset_out_rsp", {rsp_valid, rsp_write, rsp_rdata, rsp_error}, 0);
        repeat (5) begin @(posedge clk); #1; chk("idle_psel", psel, 0); end

        // Write bit period 10, back-to-back
        rlog.delete(); trace.delete();
        send(1'b1, 3'd2, 8'h0A);
        send(1'b1, 3'd3, 8'h00);
        cmd_valid = 1'b0;
        wait_rsp(2);
        chk("bit_period_10", bit_period, 16'd10);
        chk("wr_err0", rlog[0].e, 0);
        chk("wr_err1", rlog[1].e, 0);
        s = -1;
        foreach (trace[i]) if (s < 0 && trace[i][1]) s = i;
        if (s >= 0 && s + 3 < trace.size())
            chk("no_idle_gap", {trace[s], trace[s+1], trace[s+2], trace[s+3]}, 8'b10_11_10_11);
        else
            chk("no_idle_gap_found", s, 0);

        // Bit period 1000 and read-back
        rlog.delete();
        send(1'b1, 3'd2, 8'hE8);
        send(1'b1, 3'd3, 8'h03);
        send(1'b0, 3'd2, 8'h00);
        send(1'b0, 3'd3, 8'h00);
        cmd_valid = 1'b0;
        wait_rsp(4);
        chk("bit_period_1000", bit_period, 16'd1000);
        chk("wr_rdata_zero", rlog[0].d, 0);
        chk("rd_lo", rlog[2].d, 8'hE8);
        chk("rd_lo_dir", rlog[2].w, 0);
        chk("rd_hi", rlog[3].d, 8'h03);

        // Error on read-only write, following read unaffected
        rx_data = 8'h07; data_ready = 1'b1;
        rlog.delete();
        send(1'b1, 3'd0, 8'h55);
        send(1'b0, 3'd6, 8'h00);
        cmd_valid = 1'b0;
        wait_rsp(2);
        chk("ro_write_err", rlog[0].e, 1);
        chk("rx_rdata", rlog[1].d, 8'h07);
        chk("rx_err", rlog[1].e, 0);

        // Full buffer with cmd_valid held across four commands
        rlog.delete(); acc_cnt = 0; first_stall = -1;
        send(1'b1, 3'd4, 8'h11);
        send(1'b0, 3'd4, 8'h00);
        send(1'b1, 3'd4, 8'h22);
        send(1'b0, 3'd4, 8'h00);
        cmd_valid = 1'b0;
        wait_rsp(4);
        chk("stall_after_two", first_stall, 2);
        chk("order0_dir", rlog[0].w, 1);
        chk("order1_data", rlog[1].d, 8'h11);
        chk("order2_dir", rlog[2].w, 1);
        chk("order3_data", rlog[3].d, 8'h22);
        repeat (5) begin @(posedge clk); #1; end
        chk("pulse_count", rlog.size(), 4);

        // Reset during ACCESS of a queued burst
        rlog.delete();
        send(1'b1, 3'd4, 8'h33);
        send(1'b1, 3'd4, 8'h44);
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (psel && penable) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("reached_access", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_psel", psel, 0);
        chk("abort_penable", penable, 0);
        chk("abort_rsp", rsp_valid, 0);
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; chk("abort_stays_idle", psel, 0); end
        chk("abort_ready", cmd_ready, 1);
        chk("abort_no_pulse", rlog.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 Parameter ADDR_WIDTH, default 3, SHALL set the APB address width.
REQ-003 Parameter DATA_WIDTH, default 1, SHALL set the data width in bytes (bus width DATA_WIDTH*8).
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command buffer not full.
REQ-008 cmd_write  in  1  1=write, 0=read.
REQ-009 cmd_addr  in  ADDR_WIDTH  target register address.
REQ-010 cmd_wdata  in  DATA_WIDTH*8  write data, ignored for reads.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_write  out  1  direction of the completed transfer.
REQ-013 rsp_rdata  out  DATA_WIDTH*8  captured prdata; 0 for writes.
REQ-014 rsp_error  out  1  captured pslverr.
REQ-015 psel, penable, pwrite  out  1 each  APB control.
REQ-016 paddr  out  ADDR_WIDTH; pwdata  out  DATA_WIDTH*8.
REQ-017 prdata  in  DATA_WIDTH*8; pslverr  in  1  responder return, no pready, so every access completes in one ACCESS cycle.

Function
REQ-018 A command SHALL be accepted on any edge where cmd_valid and cmd_ready are both 1, and pushed into a 2-entry FIFO.
REQ-019 cmd_ready SHALL be 0 exactly when the FIFO holds 2 entries.
REQ-020 A simultaneous push and pop on a full FIFO SHALL NOT be accepted, since cmd_ready is 0.
REQ-021 A simultaneous push and pop on a non-full FIFO SHALL keep the count unchanged and preserve order.
REQ-022 FSM states SHALL be IDLE, SETUP and ACCESS.
REQ-023 IDLE->SETUP when the FIFO is non-empty; otherwise remain in IDLE.
REQ-024 SETUP->ACCESS unconditionally.
REQ-025 ACCESS->SETUP if the FIFO is non-empty after the pop, else ACCESS->IDLE.
REQ-026 Outputs per state, all registered:
- IDLE: psel=0, penable=0.
- SETUP: psel=1, penable=0.
- ACCESS: psel=1, penable=1.
REQ-027 paddr, pwrite and pwdata SHALL be loaded from the FIFO head on entry to SETUP and held stable through ACCESS.
REQ-028 The FIFO head SHALL be popped on the SETUP->ACCESS edge.
REQ-029 In IDLE, paddr, pwdata and pwrite SHALL hold their last values; there is no toggling while idle.
REQ-030 prdata and pslverr SHALL be sampled on the edge leaving ACCESS.
REQ-031 rsp_valid SHALL pulse high for exactly the next cycle, with rsp_rdata (forced to 0 for writes), rsp_write and rsp_error valid only during that pulse.
REQ-032 rsp has no backpressure; the consumer SHALL sample rsp_* on the pulse.
REQ-033 Latency: a command accepted at edge N into an empty FIFO with FSM in IDLE SHALL give SETUP in cycle N+1, ACCESS in N+2 and rsp_valid in N+3.
REQ-034 Throughput SHALL be one transfer per 2 cycles for back-to-back commands, with no IDLE cycle between them.
REQ-035 pslverr=1 SHALL NOT abort queued commands; subsequent commands still issue.

Reset
REQ-036 On rst=1 at a clock edge, the following SHALL be cleared regardless of state:
- FSM to IDLE, FIFO emptied.
- psel, penable, pwrite, paddr and pwdata to 0.
- rsp_valid, rsp_write, rsp_rdata and rsp_error to 0.
REQ-037 Reset asserted during SETUP or ACCESS SHALL drop psel and penable the following cycle and emit no rsp_valid for the aborted transfer.
REQ-038 cmd_ready SHALL be 0 while rst=1 and 1 the first cycle after release.

Structure
REQ-039 A shared package apb_pkg SHALL hold:
- the state enum (IDLE, SETUP, ACCESS);
- the command struct {write, addr, wdata};
- the register address constants 0 data status, 1 error status, 2/3 bit period low/high, 4 data size, 6 receive data.
REQ-040 The command buffer SHALL be a sub-module apb_cmd_fifo, depth 2, parameterised on the command struct width.
REQ-041 The block SHALL be synthesizable with no latches and no combinational path from prdata to any output.

Verification
REQ-042 Reset: after rst, apb_master SHALL pair with apb_slave; the bench SHALL check all outputs are 0, cmd_ready=1 and psel stays 0 for 5 idle cycles.
REQ-043 Write: write addr 2 data 0x0A, then addr 3 data 0x00 -> apb_slave bit_period=10, rsp_error=0 twice, and the SETUP/ACCESS/SETUP/ACCESS sequence has no IDLE gap.
REQ-044 Read-back: after bit period 1000, read addr 2 -> rsp_rdata=0xE8; read addr 3 -> rsp_rdata=0x03.
REQ-045 Error: write to addr 0 (read-only status) -> rsp_error=1; a following read of addr 6 with rx_data=0x07 and data_ready=1 -> rsp_rdata=0x07, rsp_error=0.
REQ-046 Full: hold cmd_valid=1 with 4 commands -> cmd_ready drops after 2 accepts, all 4 complete in order and rsp_valid pulses 4 times.
REQ-047 Reset mid-transfer: assert rst in ACCESS of a queued 2-command burst -> psel=0 the next cycle, no rsp_valid, FIFO empty.
